// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU arbiter: data width, opcodes and FSM states.
package alu_pkg;
  localparam int DW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU: add/sub/logic/compare with carry, zero and overflow flags.
module alu4_core
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          co,
  output logic          zero,
  output logic          ovf
);

  logic          use_sub;
  logic [DW-1:0] b_add;
  logic [DW:0]   sum;
  logic          add_ovf;

  // Every opcode except add feeds the adder as a subtractor; slt reuses a-b.
  assign use_sub = (op != OP_ADD);
  assign b_add   = use_sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_add} + {{DW{1'b0}}, use_sub};
  assign add_ovf = (a[DW-1] == b_add[DW-1]) && (sum[DW-1] != a[DW-1]);

  always_comb begin
    result = '0;
    co     = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[DW-1:0];
        co     = sum[DW];
        ovf    = add_ovf;
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(DW-1){1'b0}}, sum[DW-1] ^ add_ovf};
      OP_EQ:   result = {{(DW-1){1'b0}}, a == b};
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one alu4_core through a registered execute stage.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins conflicts (default round-robin).
//
// state | meaning
// IDLE  | grant computed, ready offered to the winner
// EXEC  | latched operands through the ALU, result registered
// RESP  | response held until rsp_ready
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_co,
  output logic          rsp_zero,
  output logic          rsp_ovf,
  output logic          busy
);

  state_t        state, state_nxt;
  logic          gnt;
  logic          accept;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q;
  logic          id_q;
  logic [DW-1:0] alu_result;
  logic          alu_co, alu_zero, alu_ovf;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt = req1_valid & ~req0_valid;
`else
  logic last_grant;

  // On a conflict the requester that did not win last time gets the grant.
  assign gnt = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= gnt;
  end
`endif

  assign req0_ready = (state == IDLE) & req0_valid & ~gnt;
  assign req1_ready = (state == IDLE) & req1_valid & gnt;
  assign accept     = req0_ready | req1_ready;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_co     <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= gnt ? req1_op : req0_op;
        a_q  <= gnt ? req1_a  : req0_a;
        b_q  <= gnt ? req1_b  : req0_b;
        id_q <= gnt;
      end
      if (state == EXEC) begin
        rsp_id     <= id_q;
        rsp_result <= alu_result;
        rsp_co     <= alu_co;
        rsp_zero   <= alu_zero;
        rsp_ovf    <= alu_ovf;
      end
    end
  end

  alu4_core u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .co     (alu_co),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus arbitration,
// backpressure, reset-abort and stray-ready sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_co, rsp_zero, rsp_ovf, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_co     (rsp_co),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       co;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic v);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = v;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = v;
    end
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [3:0] res,
                           input logic co, input logic zero, input logic ovf);
    chk({tag, "_valid"},  int'(rsp_valid),  1);
    chk({tag, "_id"},     int'(rsp_id),     int'(id));
    chk({tag, "_result"}, int'(rsp_result), int'(res));
    chk({tag, "_co"},     int'(rsp_co),     int'(co));
    chk({tag, "_zero"},   int'(rsp_zero),   int'(zero));
    chk({tag, "_ovf"},    int'(rsp_ovf),    int'(ovf));
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    set_req(v.id, v.op, v.a, v.b, 1'b1);
    rsp_ready = 0;
    #1;
    while (!(v.id ? req1_ready : req0_ready) && n < 10) begin
      step(); n++;
    end
    chk("vec_accept", n, 0);
    if (n >= 10) begin
      set_req(v.id, v.op, v.a, v.b, 1'b0);
      return;
    end
    step();
    set_req(v.id, v.op, v.a, v.b, 1'b0);
    chk("vec_exec_busy", int'(busy), 1);
    chk("vec_exec_novalid", int'(rsp_valid), 0);
    step();
    check_rsp("vec", v.id, v.res, v.co, v.zero, v.ovf);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("vec_done_idle", int'(busy), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, OP_SUB, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, OP_SLT, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, OP_XOR, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, OP_NOT, 4'h0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, OP_AND, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_OR,  4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, OP_EQ,  4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_EQ,  4'h5, 4'h6, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, OP_SUB, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, OP_SLT, 4'h1, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, OP_SUB, 4'h2, 4'h5, 4'hD, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, OP_SLT, 4'h2, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, OP_ADD, 4'h4, 4'h4, 4'h8, 1'b0, 1'b0, 1'b1};

    req0_op = 0; req0_a = 0; req0_b = 0;
    req1_op = 0; req1_a = 0; req1_b = 0;
    do_reset();

    // Reset state
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_result", int'(rsp_result), 0);
    chk("rst_id", int'(rsp_id), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Conflict straight out of reset: requester 0 wins, then requester 1
    do_reset();
    set_req(1'b0, OP_SUB, 4'h3, 4'h3, 1'b1);
    set_req(1'b1, OP_SLT, 4'h8, 4'h1, 1'b1);
    rsp_ready = 1;
    #1;
    chk("conf_ready0", int'(req0_ready), 1);
    chk("conf_ready1", int'(req1_ready), 0);
    step();
    req0_valid = 0;
    chk("conf_exec_ready1", int'(req1_ready), 0);
    step();
    check_rsp("conf_r0", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    chk("conf_ready1_idle", int'(req1_ready), 1);
    step();
    req1_valid = 0;
    step();
    check_rsp("conf_r1", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step();
    rsp_ready = 0;

    // Both held valid for six transactions
    do_reset();
    set_req(1'b0, OP_ADD, 4'h1, 4'h1, 1'b1);
    set_req(1'b1, OP_ADD, 4'h2, 4'h2, 1'b1);
    rsp_ready = 1;
    #1;
    begin
      int last_cyc = 0;
      for (int i = 0; i < 6; i++) begin
        int n = 0;
        int exp_id;
        while (!(req0_ready | req1_ready) && n < 10) begin
          step(); n++;
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_id = 0;
`else
        exp_id = i % 2;
`endif
        chk("rr_grant", int'(req1_ready), exp_id);
        if (i > 0) chk("rr_interval", cyc - last_cyc, 3);
        last_cyc = cyc;
        step();
      end
    end
    req0_valid = 0; req1_valid = 0;
    step(); step(); step();
    rsp_ready = 0;

    // Backpressure on a req1 xor response
    do_reset();
    set_req(1'b1, OP_XOR, 4'hA, 4'h5, 1'b1);
    #1;
    chk("bp_ready1", int'(req1_ready), 1);
    step();
    req1_valid = 0;
    step();
    set_req(1'b0, OP_ADD, 4'h2, 4'h3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_rsp("bp_hold", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
      step();
    end
    rsp_ready = 1;
    #1;
    chk("bp_take_ready0", int'(req0_ready), 0);
    step();
    rsp_ready = 0;
    #1;
    chk("bp_next_valid", int'(rsp_valid), 0);
    chk("bp_next_ready0", int'(req0_ready), 1);
    step();
    req0_valid = 0;
    chk("bp_next_busy", int'(busy), 1);
    step();
    check_rsp("bp_next", 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Reset during EXEC discards the operation
    set_req(1'b0, OP_EQ, 4'h5, 4'h5, 1'b1);
    #1;
    chk("rx_ready0", int'(req0_ready), 1);
    step();
    req0_valid = 0;
    chk("rx_exec_busy", int'(busy), 1);
    rst = 1;
    step();
    rst = 0;
    chk("rx_valid", int'(rsp_valid), 0);
    chk("rx_busy", int'(busy), 0);
    chk("rx_result", int'(rsp_result), 0);
    chk("rx_flags", int'({rsp_co, rsp_zero, rsp_ovf, rsp_id}), 0);
    begin
      int seen = 0;
      rsp_ready = 1;
      for (int k = 0; k < 6; k++) begin
        if (rsp_valid) seen++;
        step();
      end
      rsp_ready = 0;
      chk("rx_no_rsp", seen, 0);
    end

    // Stray rsp_ready while idle
    do_reset();
    set_req(1'b1, OP_NOT, 4'h0, 4'h0, 1'b1);
    rsp_ready = 1;
    #1;
    chk("st_ready1", int'(req1_ready), 1);
    step();
    req1_valid = 0;
    rsp_ready = 0;
    chk("st_exec_busy", int'(busy), 1);
    step();
    check_rsp("st", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    step();
    chk("st_still_valid", int'(rsp_valid), 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("st_done", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
